maj_netlist_tt_eval: RTL
========================

// Module: maj_netlist_tt_eval
// PURPOSE
//  Inverse of our majority-network netlists: takes a programmed chain of 3-input
//  majority nodes and computes the full truth table of the selected output.
//  Evaluation is bit-parallel over all 2^NUM_VARS minterms, one node per cycle.
//  The result is 2^NUM_VARS bits wide (128 for 7 inputs).
//  Used by the classification flow to check that a synthesized MAJ netlist
//  matches its target truth table.
// PARAMETERS
//  NUM_VARS   7   primary inputs x0..x(NUM_VARS-1); TT_W = 2**NUM_VARS
//  MAX_NODES  8   majority node slots
//  SEL_W      4   operand select width = clog2(1+NUM_VARS+MAX_NODES)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         synchronous reset, active-low
//  prog_valid  in   1         node program write request
//  prog_ready  out  1         high only in IDLE
//  prog_idx    in   clog2(MAX_NODES)  node slot being written
//  prog_sel    in   3*SEL_W   operands {c,b,a}: 0=const0, 1+i=x_i, 1+NUM_VARS+k=node k
//  prog_inv    in   3         per-operand invert {c,b,a}
//  num_nodes   in   clog2(MAX_NODES+1)  node count, sampled on start
//  out_sel     in   SEL_W     output operand select, sampled on start
//  out_inv     in   1         output invert, sampled on start
//  start       in   1         begin evaluation; accepted only in IDLE
//  busy        out  1         high in EVAL and DONE
//  tt_valid    out  1         truth table available
//  tt_ready    in   1         consumer accepts tt_data
//  tt_data     out  TT_W      bit m = f(minterm m); bit i of m = x_i
//  err         out  1         sticky per run: forward/self reference or out-of-range select
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//      state=IDLE; all outputs 0 except prog_ready=1.
//      All program slots cleared (sel=0, inv=0); node result regs cleared.
//  - Variable tables are constants: x_i bit m = (m>>i)&1.
//      x0 = 128'hAAAA..., x6 = upper 64 bits set.
//  - Node k = MAJ(a^ia, b^ib, c^ic), bitwise on TT_W-bit vectors.
//  - IDLE:
//      prog_valid writes slot prog_idx.
//      start latches num_nodes/out_sel/out_inv, clears err, moves to EVAL at k=0.
//      prog_valid and start in the same cycle are both accepted; the write is
//      visible to evaluation.
//  - EVAL:
//      One node per cycle: node k result stored at the edge, k increments.
//      Operand referencing node j>=k, or select > NUM_VARS+MAX_NODES: operand reads 0, err=1.
//      After node num_nodes-1 goes to DONE.
//      num_nodes=0 goes straight to DONE.
//      num_nodes>MAX_NODES is clamped to MAX_NODES and sets err.
//  - DONE:
//      tt_data = out_operand ^ {TT_W{out_inv}}; out_sel uses the same decode as nodes.
//      tt_valid=1 with tt_data stable until tt_valid&&tt_ready, then IDLE next cycle.
//      err is held valid alongside tt_valid.
//  - Latency: start accepted at edge T -> tt_valid high from edge T+num_nodes+1.
//  - prog_valid outside IDLE is ignored (prog_ready=0); start outside IDLE is ignored.
//  - rst_n low mid-EVAL or DONE aborts: no tt_valid pulse, program lost.
// STRUCTURE
//  - Package maj_eval_pkg:
//      TT_W, SEL_CONST0, SEL_VAR_BASE, SEL_NODE_BASE.
//      typedef node_cfg_t {sel_a,sel_b,sel_c,inv[2:0]}.
//      state_t {IDLE,EVAL,DONE}.
//      function var_tt(i) returning the x_i constant pattern.
//  - Sub-module maj_operand_mux: select+invert+node-range check -> TT_W vector, bad flag.
//      Instantiated 3x for node operands and 1x for output.
//  - Top holds FSM, node counter, program regs, MAX_NODES x TT_W result regs.
// TESTING
//  1. Single node MAJ(x0,x1,x2), out_sel=node0
//       -> tt_data = {16{8'hE8}}, err=0, tt_valid 2 cycles after start.
//  2. num_nodes=0, out_sel=const0, out_inv=1
//       -> tt_data all ones next cycle.
//     out_sel=x6, out_inv=0
//       -> upper 64 bits 1, lower 0.
//  3. Five-node chain:
//       n0=MAJ(x4,x5,x6); n1=MAJ(x0,x2,x3); n2=MAJ(x3,x4,n1);
//       n3=MAJ(x2,n0,n2); n4=MAJ(x0,x1,n3); out=n4
//       -> tt_data = 128'heee8eae8eee8e888eee8e888e8a8e888.
//  4. Node0 operand selects node2
//       -> err=1; that operand treated as 0.
//  5. Backpressure: hold tt_ready=0 for 5 cycles
//       -> tt_valid and tt_data stable throughout; IDLE one cycle after handshake.
//     start and prog writes during busy are ignored.
//  6. rst_n=0 during EVAL of a 5-node run
//       -> next cycle IDLE, tt_valid=0, busy=0, prog_ready=1.
//     Restarting without reprogramming a single-node run yields all zeros.

Source files
------------

// File: rtl/maj_eval_pkg.sv
// Shared constants, types and the primary-input truth-table generator for
// the majority-netlist truth-table evaluator.
package maj_eval_pkg;

  localparam int NUM_VARS      = 7;
  localparam int MAX_NODES     = 8;
  localparam int SEL_W         = 4;
  localparam int TT_W          = 2 ** NUM_VARS;
  localparam int IDX_W         = $clog2(MAX_NODES);
  localparam int CNT_W         = $clog2(MAX_NODES + 1);
  localparam int SEL_CONST0    = 0;
  localparam int SEL_VAR_BASE  = 1;
  localparam int SEL_NODE_BASE = 1 + NUM_VARS;
  localparam int SEL_MAX       = NUM_VARS + MAX_NODES;

  typedef struct packed {
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_c;
    logic [2:0]       inv;
  } node_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit m of x_i is bit i of the minterm index m.
  function automatic logic [TT_W-1:0] var_tt(input int i);
    logic [TT_W-1:0] v;
    for (int m = 0; m < TT_W; m++) v[m] = ((m >> i) & 1) != 0;
    return v;
  endfunction

endpackage

// File: rtl/maj_operand_mux.sv
// Decodes one operand select into a TT_W-bit vector; node references at or
// beyond `limit` and out-of-range selects read as 0 and raise `bad`.
module maj_operand_mux
  import maj_eval_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             inv,
  input  logic [CNT_W-1:0] limit,
  input  logic [TT_W-1:0]  nodes [MAX_NODES],
  output logic [TT_W-1:0]  vec,
  output logic             bad
);

  logic [TT_W-1:0]  raw;
  logic [IDX_W-1:0] node_idx;

  assign node_idx = IDX_W'(sel - SEL_W'(SEL_NODE_BASE));

  always_comb begin
    raw = '0;
    bad = 1'b0;
    if (int'(sel) == SEL_CONST0) begin
      raw = '0;
    end else if (int'(sel) < SEL_NODE_BASE) begin
      raw = var_tt(int'(sel) - SEL_VAR_BASE);
    end else if (int'(sel) > SEL_MAX) begin
      bad = 1'b1;
    end else if (int'(sel) - SEL_NODE_BASE < int'(limit)) begin
      raw = nodes[node_idx];
    end else begin
      bad = 1'b1;
    end
  end

  // The invert applies after decode, so a rejected operand becomes 0^inv.
  assign vec = raw ^ {TT_W{inv}};

endmodule

// File: rtl/maj_netlist_tt_eval.sv
// Evaluates a programmed chain of 3-input majority nodes bit-parallel over all
// minterms, one node per cycle, and presents the selected output's truth table.
module maj_netlist_tt_eval
  import maj_eval_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prog_valid,
  output logic                 prog_ready,
  input  logic [IDX_W-1:0]     prog_idx,
  input  logic [3*SEL_W-1:0]   prog_sel,
  input  logic [2:0]           prog_inv,
  input  logic [CNT_W-1:0]     num_nodes,
  input  logic [SEL_W-1:0]     out_sel,
  input  logic                 out_inv,
  input  logic                 start,
  output logic                 busy,
  output logic                 tt_valid,
  input  logic                 tt_ready,
  output logic [TT_W-1:0]      tt_data,
  output logic                 err
);

  state_t           state, state_nxt;
  node_cfg_t        prog_q [MAX_NODES];
  logic [TT_W-1:0]  node_q [MAX_NODES];
  logic [CNT_W-1:0] k_q, n_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             out_inv_q, err_q;

  node_cfg_t        cur;
  logic [IDX_W-1:0] k_idx;
  logic             clamp, eval_step;
  logic [CNT_W-1:0] n_start;
  logic [TT_W-1:0]  opa, opb, opc, maj_vec, out_vec;
  logic             bad_a, bad_b, bad_c, out_bad;

  assign k_idx     = k_q[IDX_W-1:0];
  assign cur       = prog_q[k_idx];
  assign clamp     = num_nodes > CNT_W'(MAX_NODES);
  assign n_start   = clamp ? CNT_W'(MAX_NODES) : num_nodes;
  assign eval_step = (state == EVAL) && (k_q != n_q);

  maj_operand_mux u_op_a (.sel(cur.sel_a), .inv(cur.inv[0]), .limit(k_q), .nodes(node_q), .vec(opa), .bad(bad_a));
  maj_operand_mux u_op_b (.sel(cur.sel_b), .inv(cur.inv[1]), .limit(k_q), .nodes(node_q), .vec(opb), .bad(bad_b));
  maj_operand_mux u_op_c (.sel(cur.sel_c), .inv(cur.inv[2]), .limit(k_q), .nodes(node_q), .vec(opc), .bad(bad_c));
  maj_operand_mux u_op_o (.sel(out_sel_q), .inv(out_inv_q), .limit(n_q), .nodes(node_q), .vec(out_vec), .bad(out_bad));

  assign maj_vec = (opa & opb) | (opa & opc) | (opb & opc);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // EVAL spends one extra cycle at k == n_q, so tt_valid rises n+1 edges after start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EVAL;
      EVAL:    if (k_q == n_q) state_nxt = DONE;
      DONE:    if (tt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prog_ready = (state == IDLE);
    busy       = (state != IDLE);
    tt_valid   = (state == DONE);
    tt_data    = tt_valid ? out_vec : '0;
    err        = err_q | (tt_valid & out_bad);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        prog_q[i] <= '0;
        node_q[i] <= '0;
      end
      k_q       <= '0;
      n_q       <= '0;
      out_sel_q <= '0;
      out_inv_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && prog_valid)
        prog_q[prog_idx] <= '{sel_a: prog_sel[SEL_W-1:0],
                              sel_b: prog_sel[2*SEL_W-1:SEL_W],
                              sel_c: prog_sel[3*SEL_W-1:2*SEL_W],
                              inv:   prog_inv};
      if (state == IDLE && start) begin
        n_q       <= n_start;
        out_sel_q <= out_sel;
        out_inv_q <= out_inv;
        err_q     <= clamp;
        k_q       <= '0;
      end
      if (eval_step) begin
        node_q[k_idx] <= maj_vec;
        err_q         <= err_q | bad_a | bad_b | bad_c;
        k_q           <= k_q + 1'b1;
      end
      if (state == DONE) err_q <= err_q | out_bad;
    end
  end

endmodule
